// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit queue and its sequencer.
package uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOAD      = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } uart_tx_state_e;

  localparam int unsigned UART_BYTE_W = 8;
  localparam int unsigned WDOG_LIMIT  = 15;

endpackage

// File: rtl/sync_fifo.sv
// Circular byte queue with a separate level counter and a sticky overflow flag.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned DATA_W     = UART_BYTE_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                pop,
  input  logic                clr_ovf,
  output logic [DATA_W-1:0]   rd_data,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] level,
  output logic                overflow
);

  localparam int unsigned         Depth   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FullLvl = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [DATA_W-1:0]     mem [Depth];
  logic [DEPTH_LOG2-1:0] wptr_q, rptr_q;
  logic [DEPTH_LOG2:0]   level_q;
  logic                  ovf_q;
  logic                  push, do_pop;

  assign full     = (level_q == FullLvl);
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign overflow = ovf_q;
  assign rd_data  = mem[rptr_q];

  // full/empty come from registered state, so a same-cycle pop never frees room for a push
  assign push   = wr_en && !full;
  assign do_pop = pop && !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (do_pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      case ({push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      if (wr_en && full) begin
        ovf_q <= 1'b1;
      end else if (clr_ovf) begin
        ovf_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte queue plus transmit sequencer that paces strobes against the UART busy flag.
// Define UART_TX_FIFO_WDOG_EN to re-strobe when busy_tx never rises after a strobe.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned DATA_W     = UART_BYTE_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                clr_ovf,
  input  logic                busy_tx,
  output logic                transmit,
  output logic [DATA_W-1:0]   data_tx,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] level,
  output logic                overflow,
  output logic                err_wdog
);

  uart_tx_state_e    state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] rd_data;
  logic              pop;
  logic              wdog_fire;

  sync_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_W     (DATA_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .pop      (pop),
    .clr_ovf  (clr_ovf),
    .rd_data  (rd_data),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow)
  );

`ifdef UART_TX_FIFO_WDOG_EN
  logic [3:0] wdog_q;

  // Fires on the last allowed S_WAIT_BUSY cycle; counter restarts on every entry
  assign wdog_fire = (state_q == S_WAIT_BUSY) && !busy_tx && (wdog_q == 4'(WDOG_LIMIT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q <= '0;
    end else if (state_q == S_WAIT_BUSY) begin
      wdog_q <= wdog_q + 4'd1;
    end else begin
      wdog_q <= '0;
    end
  end
`else
  assign wdog_fire = 1'b0;
`endif

  assign err_wdog = wdog_fire;
  assign transmit = (state_q == S_LOAD);
  assign data_tx  = data_q;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty && !busy_tx) begin
          pop     = 1'b1;
          data_d  = rd_data;
          state_d = S_LOAD;
        end
      end
      S_LOAD: state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (busy_tx) begin
          state_d = S_WAIT_DONE;
        end else if (wdog_fire) begin
          state_d = S_LOAD;
        end
      end
      S_WAIT_DONE: begin
        if (!busy_tx) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: vector table for queue flags plus a UART model
// whose strobes are scored against a queue of expected bytes.
module tb_uart_tx_fifo;

`ifdef UART_TX_FIFO_WDOG_EN
  localparam bit WdogEn = 1'b1;
`else
  localparam bit WdogEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       clr_ovf = 1'b0;
  logic       busy_tx = 1'b0;
  logic       transmit;
  logic [7:0] data_tx;
  logic       full, empty, overflow, err_wdog;
  logic [4:0] level;

  int  total = 0;
  int  bad = 0;
  int  strobe_cnt = 0;
  int  busy_len = 8;
  int  busy_cnt = 0;
  bit  force_busy = 1'b0;
  bit  dead = 1'b0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       clr;
    int         lvl;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       acc;
  } vec_t;

  vec_t vecs[21];

  uart_tx_fifo #(
    .DEPTH_LOG2 (4),
    .DATA_W     (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .clr_ovf  (clr_ovf),
    .busy_tx  (busy_tx),
    .transmit (transmit),
    .data_tx  (data_tx),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow),
    .err_wdog (err_wdog)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // UART model: raises busy the cycle after it sees a strobe and holds it busy_len cycles
  always @(posedge clk) begin
    #2;
    if (transmit) begin
      strobe_cnt++;
      chk("busy_at_strobe", 32'(busy_tx), 0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: got data_tx=%0h, want no strobe (t=%0t)", data_tx, $time);
      end else begin
        chk("strobe_data", 32'(data_tx), 32'(exp_q.pop_front()));
      end
      if (!dead) busy_cnt = busy_len;
    end
    busy_tx = force_busy || (busy_cnt > 0);
    if (busy_cnt > 0) busy_cnt--;
  end

  task automatic push_byte(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    exp_q.push_back(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while ((exp_q.size() != 0 || busy_tx || !empty) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int s0;
    int n;

    for (int i = 0; i < 16; i++) begin
      vecs[i] = '{1'b1, 8'(i + 1), 1'b0, i + 1, (i == 15), 1'b0, 1'b0, 1'b1};
    end
    vecs[16] = '{1'b1, 8'hFF, 1'b0, 16, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[17] = '{1'b0, 8'h00, 1'b1, 16, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 8'hEE, 1'b1, 16, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[19] = '{1'b0, 8'h00, 1'b1, 16, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 8'h00, 1'b0, 16, 1'b1, 1'b0, 1'b0, 1'b0};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_transmit", 32'(transmit), 0);
    chk("rst_data_tx", 32'(data_tx), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_err_wdog", 32'(err_wdog), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte: strobe exactly two cycles after the push
    busy_len = 87;
    wr_en = 1'b1;
    wr_data = 8'hA5;
    exp_q.push_back(8'hA5);
    @(negedge clk);
    wr_en = 1'b0;
    chk("single_level_n1", 32'(level), 1);
    chk("single_tx_n1", 32'(transmit), 0);
    @(negedge clk);
    chk("single_tx_n2", 32'(transmit), 1);
    chk("single_data_n2", 32'(data_tx), 32'h A5);
    @(negedge clk);
    chk("single_tx_n3", 32'(transmit), 0);
    drain(200);
    repeat (5) @(negedge clk);
    chk("single_strobes", 32'(strobe_cnt), 1);
    chk("single_data_hold", 32'(data_tx), 32'h A5);

    // Fill while the UART is held busy, overflow, clear, set-wins
    busy_len = 8;
    force_busy = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 21; i++) begin
      wr_en   = vecs[i].wr;
      wr_data = vecs[i].d;
      clr_ovf = vecs[i].clr;
      if (vecs[i].acc) exp_q.push_back(vecs[i].d);
      @(negedge clk);
      wr_en   = 1'b0;
      clr_ovf = 1'b0;
      chk($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].lvl));
      chk($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].full));
      chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].empty));
      chk($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vecs[i].ovf));
      chk($sformatf("vec%0d_transmit", i), 32'(transmit), 0);
    end
    s0 = strobe_cnt;
    force_busy = 1'b0;
    drain(500);
    chk("burst_strobes", 32'(strobe_cnt - s0), 16);
    chk("burst_empty", 32'(empty), 1);
    chk("burst_level", 32'(level), 0);
    chk("burst_overflow", 32'(overflow), 0);

    // Simultaneous push and pop at level 3
    force_busy = 1'b1;
    repeat (2) @(negedge clk);
    push_byte(8'h31);
    push_byte(8'h32);
    push_byte(8'h33);
    chk("pp_pre_level", 32'(level), 3);
    force_busy = 1'b0;
    @(negedge clk);
    push_byte(8'h77);
    chk("pp_level", 32'(level), 3);
    drain(300);

    // Stream 40 bytes so both pointers wrap
    busy_len = 3;
    s0 = strobe_cnt;
    for (int i = 0; i < 40; i++) begin
      n = 0;
      while (full && n < 1000) begin
        @(negedge clk);
        n++;
      end
      push_byte(8'(i * 7 + 3));
    end
    drain(800);
    chk("wrap_strobes", 32'(strobe_cnt - s0), 40);
    chk("wrap_empty", 32'(empty), 1);

    // Reset while waiting for the frame to finish with 5 bytes queued
    busy_len = 60;
    s0 = strobe_cnt;
    for (int i = 0; i < 6; i++) push_byte(8'(8'h90 + i));
    repeat (3) @(negedge clk);
    chk("mid_pre_level", 32'(level), 5);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("mid_level", 32'(level), 0);
    chk("mid_empty", 32'(empty), 1);
    chk("mid_transmit", 32'(transmit), 0);
    chk("mid_overflow", 32'(overflow), 0);
    rst = 1'b0;
    push_byte(8'h5A);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("mid_hold%0d", i), 32'(transmit), 0);
    end
    drain(200);
    chk("mid_strobes", 32'(strobe_cnt - s0), 2);

    // UART never answers: watchdog re-strobe, or a silent stall without it
    busy_len = 8;
    dead = 1'b1;
    s0 = strobe_cnt;
    push_byte(8'h3C);
    if (WdogEn) exp_q.push_back(8'h3C);
    n = 0;
    while (!transmit && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wdog_first_strobe", 32'(transmit), 1);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      chk($sformatf("wdog_err_c%0d", c), 32'(err_wdog), 32'(WdogEn && c == 15));
      chk($sformatf("wdog_tx_c%0d", c), 32'(transmit), 32'(WdogEn && c == 16));
    end
    chk("wdog_data_hold", 32'(data_tx), 32'h3C);
    dead = 1'b0;
    force_busy = 1'b1;
    repeat (3) @(negedge clk);
    force_busy = 1'b0;
    drain(100);
    chk("wdog_strobes", 32'(strobe_cnt - s0), WdogEn ? 2 : 1);
    chk("wdog_err_end", 32'(err_wdog), 0);
    chk("wdog_empty", 32'(empty), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
